instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Front-end stage feeding the cpu decode stage. Owns the fetch PC and issues word reads to a
//  synchronous instruction memory (1-cycle read latency). Buffers returned {pc, instr} pairs in a
//  small FIFO and hands them to decode over a valid/ready handshake. Accepts branch/jump redirects
//  from execute, which flush all buffered and in-flight fetches.
// PARAMETERS
//  XLEN        32        data/PC width
//  RESET_PC    32'h0     fetch PC after reset
//  FIFO_DEPTH  2         fetch buffer entries (>=2, power of two)
//  IMEM_AW     8         instruction memory word-address width
// PORTS
//  clk             in   1        single clock, rising edge
//  rst             in   1        asynchronous reset, active-high
//  imem_req        out  1        read request this cycle
//  imem_addr       out  IMEM_AW  word address = fetch_pc[IMEM_AW+1:2]
//  imem_rdata      in   32       instruction, valid exactly 1 cycle after imem_req
//  redirect_valid  in   1        execute redirects fetch this cycle
//  redirect_pc     in   XLEN     redirect target (bits [1:0] ignored, forced 0)
//  out_valid       out  1        {out_pc, out_instr} valid to decode
//  out_ready       in   1        decode accepts this cycle
//  out_pc          out  XLEN     PC of presented instruction
//  out_instr       out  32       presented instruction
// BEHAVIOUR
//  Reset (async, any time): fetch_pc=RESET_PC, FIFO empty, inflight=0, imem_req=0, out_valid=0,
//   out_pc=0, out_instr=0 (NOP not inserted). Any response due after reset is discarded.
//  Issue rule: imem_req=1 iff !rst && !redirect_valid && (count + inflight - pop) < FIFO_DEPTH,
//   where pop = out_valid && out_ready. On issue: inflight<=1, resp_pc<=fetch_pc, fetch_pc+=4.
//  fetch_pc+4 wraps modulo 2^XLEN; no exception raised.
//  Response: cycle after issue, if not killed, push {resp_pc, imem_rdata} into FIFO. Never
//   bypassed: entry visible at out_valid the following cycle. Latency req->out_valid = 2 cycles.
//  Steady state (out_ready=1): one instruction per cycle, no bubbles, with FIFO_DEPTH=2.
//  FIFO full: issue rule guarantees no push into a full FIFO; push on full is an assertion error.
//  Simultaneous push and pop: both occur; count unchanged.
//  Redirect (redirect_valid=1 at edge): fetch_pc<=redirect_pc&~3, FIFO flushed, in-flight
//   response marked killed (dropped next cycle), imem_req=0 that cycle. First request to target
//   issues next cycle; target instruction reaches out_valid 3 cycles after redirect cycle.
//  Redirect and out handshake same cycle: handshake counts as completed; decode squashes it.
//  out_valid is registered state only; no combinational path redirect_valid/out_ready->out_valid.
//  Back-to-back redirects: last one wins; each kills the previous in-flight request.
//  out_* stable while out_valid && !out_ready (no redirect).
// STRUCTURE
//  rv_pkg (shared): XLEN, ILEN=32, RESET_PC, INSTR_NOP=32'h00000013, fetch_entry_t {pc, instr}.
//  Sub-module fetch_fifo: parameterised sync FIFO (push, pop, flush, full, empty, count),
//   async-reset pointers, flush has priority over push.
//  Top: fetch_pc reg, inflight/killed flags, resp_pc reg, issue logic.
// TESTING
//  Reset release, imem preloaded word[i]=i, out_ready=1 -> first out_valid 2 cycles later with
//   out_pc=0, then pc=4,8,12.. one per cycle, out_instr=pc>>2.
//  out_ready=0 for 10 cycles -> exactly 2 entries buffered, imem_req=0 while full; release ->
//   pcs continue contiguously, none lost or duplicated.
//  Redirect to 32'h40 while FIFO full and request in flight -> no old pc appears; next out_pc=0x40
//   exactly 3 cycles after redirect; redirect_pc=0x43 gives out_pc=0x40.
//  Redirect in two consecutive cycles (0x80 then 0xC0) -> first out_pc=0xC0, 0x80 never seen.
//  fetch_pc near 2^XLEN-4 (via redirect) -> sequence 0xFFFFFFFC, 0x00000000.
//  Assert rst mid-stream with entries buffered -> outputs zero immediately (async); after release
//   fetch restarts at RESET_PC, stale response never pushed.

Source files
------------

// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
//   Shared definitions for the cpu front end: machine widths, reset PC,
//   canonical NOP encoding and the {pc, instr} record carried from fetch to
//   decode.
// ---------------------------------------------------------------------------
package rv_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned ILEN      = 32;
   localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
   localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
//   Synchronous FIFO buffering fetched {pc, instr} words for decode.
//   Flush has priority over push and pop. The head word reads as zero while
//   the FIFO is empty, so downstream outputs are clean whenever nothing is
//   valid.
// Ports
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous active-high reset (pointers, count)
//   push       in   1        write push_data this cycle
//   pop        in   1        remove head entry this cycle
//   flush      in   1        discard all entries (wins over push/pop)
//   push_data  in   WIDTH    word to write
//   head_data  out  WIDTH    oldest entry (zero when empty)
//   full       out  1        count == DEPTH
//   empty      out  1        count == 0
//   count      out  AW+1     number of stored entries
// ---------------------------------------------------------------------------
module fetch_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         push_data,
   output logic [WIDTH-1:0]         head_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push   = push && !flush;
   assign do_pop    = pop && !flush && !empty;
   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign head_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage needs no reset: nothing is observable until count says so.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Front-end fetch stage. Owns the fetch PC, issues word reads to a
//   1-cycle-latency synchronous instruction memory, buffers returned
//   {pc, instr} pairs in fetch_fifo and presents them to decode over a
//   valid/ready handshake. A redirect from execute reloads the PC, flushes
//   the buffer and drops any response still in flight.
// Ports
//   clk             in   1        rising-edge clock
//   rst             in   1        asynchronous active-high reset
//   imem_req        out  1        read request this cycle
//   imem_addr       out  IMEM_AW  word address (fetch_pc[IMEM_AW+1:2])
//   imem_rdata      in   ILEN     read data, one cycle after imem_req
//   redirect_valid  in   1        execute redirects fetch this cycle
//   redirect_pc     in   XLEN     redirect target (low two bits ignored)
//   out_valid       out  1        out_pc/out_instr valid to decode
//   out_ready       in   1        decode accepts this cycle
//   out_pc          out  XLEN     PC of presented instruction
//   out_instr       out  ILEN     presented instruction
// ---------------------------------------------------------------------------
module instr_fetch_unit
   import rv_pkg::*;
#(
   parameter int unsigned     XLEN       = rv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC   = XLEN'(rv_pkg::RESET_PC),
   parameter int unsigned     FIFO_DEPTH = 2,
   parameter int unsigned     IMEM_AW    = 8
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [ILEN-1:0]    imem_rdata,
   input  logic               redirect_valid,
   input  logic [XLEN-1:0]    redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [XLEN-1:0]    out_pc,
   output logic [ILEN-1:0]    out_instr
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned OW = CW + 1;
   localparam int unsigned EW = XLEN + ILEN;

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] resp_pc;
   logic            inflight;
   logic            push;
   logic            pop;
   logic            full;
   logic            empty;
   logic [CW-1:0]   count;
   logic [OW-1:0]   occupancy;
   logic [EW-1:0]   head;

   assign pop       = out_valid && out_ready;
   // Entries that will hold buffer space after this edge: stored plus the
   // returning response, minus the one decode takes now.
   assign occupancy = OW'(count) + OW'(inflight) - OW'(pop);
   assign imem_req  = !rst && !redirect_valid && (occupancy < OW'(FIFO_DEPTH));
   assign imem_addr = fetch_pc[IMEM_AW+1:2];

   // A killed request's response always returns in the redirect cycle itself,
   // so gating push with redirect_valid (and the FIFO's flush priority) drops
   // it without a separate killed flag.
   assign push      = inflight && !redirect_valid;

   assign out_valid = !empty;
   assign {out_pc, out_instr} = head;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         resp_pc  <= '0;
         inflight <= 1'b0;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_pc & ~XLEN'(3);
         inflight <= 1'b0;
      end else begin
         inflight <= imem_req;
         if (imem_req) begin
            resp_pc  <= fetch_pc;
            fetch_pc <= fetch_pc + XLEN'(4);
         end
      end
   end

   fetch_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .flush     (redirect_valid),
      .push_data ({resp_pc, imem_rdata}),
      .head_data (head),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   // The issue rule reserves a slot for every request, so a push can never
   // meet a full buffer.
   always_ff @(posedge clk) begin
      if (!rst) assert (!(push && full));
   end

endmodule
